// File: rtl/pll_reset_seq_pkg.sv
// Shared definitions for the MMCM reset/lock sequencer: state encoding,
// status counter widths and saturating increment helpers.
package pll_reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_RST_HOLD  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_READY     = 3'd3,
      ST_FAIL      = 3'd4
   } pll_state_e;

   localparam int unsigned RETRY_W = 3;
   localparam int unsigned LOSS_W  = 8;

   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;
   localparam logic [LOSS_W-1:0]  LOSS_MAX  = '1;

   // Retry counter increment that sticks at all-ones
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
      return (v == RETRY_MAX) ? v : v + RETRY_W'(1);
   endfunction

   // Lock-loss counter increment that sticks at all-ones
   function automatic logic [LOSS_W-1:0] loss_inc(input logic [LOSS_W-1:0] v);
      return (v == LOSS_MAX) ? v : v + LOSS_W'(1);
   endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchronizer for the asynchronous MMCM LOCKED signal.
module pll_reset_seq_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE" *) logic sync_q;

   // Two-stage capture; cleared together with the sequencer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Reset/lock sequencer for the MMCM clock wrapper. Pulses the MMCM reset,
// qualifies LOCKED for a stable window, retries on timeout, parks the MMCM
// in FAIL once retries are exhausted, and counts lock losses after ready.
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRY     = 4,
   parameter int unsigned CNT_W         = 17
) (
   input  logic               clk_ref,
   input  logic               reset_n,
   input  logic               pll_restart,
   input  logic               pll_lock,
   output logic               pll_reset,
   output logic               pll_ready,
   output logic               lock_err,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  loss_cnt
);

   localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);

   pll_state_e         state_q;
   logic [CNT_W-1:0]   timer_q;
   logic [CNT_W-1:0]   timer_inc;
   logic               pll_reset_q;
   logic               pll_ready_q;
   logic               lock_err_q;
   logic [RETRY_W-1:0] retry_q;
   logic [LOSS_W-1:0]  loss_q;
   logic               lock_s;

   // Bring LOCKED into the clk_ref domain; every decision uses lock_s
   pll_reset_seq_sync_2ff u_lock_sync (
      .clk   (clk_ref),
      .rst_n (reset_n),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

   assign timer_inc = timer_q + CNT_W'(1);

   // Sequencer: reset_n beats pll_restart beats normal transitions
   always_ff @(posedge clk_ref) begin
      if (!reset_n) begin
         state_q     <= ST_RST_HOLD;
         timer_q     <= '0;
         pll_reset_q <= 1'b1;
         pll_ready_q <= 1'b0;
         lock_err_q  <= 1'b0;
         retry_q     <= '0;
         loss_q      <= '0;
      end else if (pll_restart) begin
         state_q     <= ST_RST_HOLD;
         timer_q     <= '0;
         pll_reset_q <= 1'b1;
         pll_ready_q <= 1'b0;
         lock_err_q  <= 1'b0;
         retry_q     <= '0;
      end else begin
         case (state_q)
            ST_RST_HOLD: begin
               pll_reset_q <= 1'b1;
               pll_ready_q <= 1'b0;
               if (timer_q == HOLD_LAST) begin
                  state_q     <= ST_WAIT_LOCK;
                  timer_q     <= '0;
                  pll_reset_q <= 1'b0;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            ST_WAIT_LOCK: begin
               // A lock arriving on the timeout cycle takes precedence
               if (lock_s) begin
                  state_q <= ST_STABLE;
                  timer_q <= '0;
               end else if (timer_q == WAIT_LAST) begin
                  timer_q <= '0;
                  if (retry_q == RETRY_LIM) begin
                     state_q     <= ST_FAIL;
                     pll_reset_q <= 1'b1;
                     lock_err_q  <= 1'b1;
                  end else begin
                     state_q     <= ST_RST_HOLD;
                     pll_reset_q <= 1'b1;
                     retry_q     <= retry_inc(retry_q);
                  end
               end else begin
                  timer_q <= timer_inc;
               end
            end
            ST_STABLE: begin
               // A dropout sends us back to waiting without spending a retry
               if (!lock_s) begin
                  state_q <= ST_WAIT_LOCK;
                  timer_q <= '0;
               end else if (timer_q == STABLE_LAST) begin
                  state_q     <= ST_READY;
                  timer_q     <= '0;
                  pll_ready_q <= 1'b1;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            ST_READY: begin
               if (!lock_s) begin
                  state_q     <= ST_RST_HOLD;
                  timer_q     <= '0;
                  pll_ready_q <= 1'b0;
                  pll_reset_q <= 1'b1;
                  retry_q     <= '0;
                  loss_q      <= loss_inc(loss_q);
               end
            end
            ST_FAIL: begin
               pll_reset_q <= 1'b1;
               pll_ready_q <= 1'b0;
               lock_err_q  <= 1'b1;
            end
            default: begin
               state_q     <= ST_RST_HOLD;
               timer_q     <= '0;
               pll_reset_q <= 1'b1;
               pll_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign pll_reset = pll_reset_q;
   assign pll_ready = pll_ready_q;
   assign lock_err  = lock_err_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with short timing parameters: directed scenarios
// with hand-computed expectations plus a per-cycle behavioural model.
module tb_pll_reset_seq;

   localparam int unsigned RSTC = 4;
   localparam int unsigned TMO  = 32;
   localparam int unsigned STB  = 8;
   localparam int unsigned MAXR = 2;

   logic       clk_ref     = 1'b0;
   logic       reset_n     = 1'b0;
   logic       pll_restart = 1'b0;
   logic       pll_lock    = 1'b0;
   logic       pll_reset;
   logic       pll_ready;
   logic       lock_err;
   logic [2:0] retry_cnt;
   logic [7:0] loss_cnt;

   int errors = 0;
   int checks = 0;

   pll_reset_seq #(
      .RST_CYCLES    (RSTC),
      .LOCK_TIMEOUT  (TMO),
      .STABLE_CYCLES (STB),
      .MAX_RETRY     (MAXR),
      .CNT_W         (17)
   ) dut (
      .clk_ref     (clk_ref),
      .reset_n     (reset_n),
      .pll_restart (pll_restart),
      .pll_lock    (pll_lock),
      .pll_reset   (pll_reset),
      .pll_ready   (pll_ready),
      .lock_err    (lock_err),
      .retry_cnt   (retry_cnt),
      .loss_cnt    (loss_cnt)
   );

   always #5 clk_ref = ~clk_ref;

   // Behavioural model: phase plus cycles elapsed in that phase
   localparam int P_HOLD = 0, P_WAIT = 1, P_QUAL = 2, P_UP = 3, P_PARK = 4;
   int   m_phase = P_HOLD;
   int   m_elapsed = 0;
   bit   m_hist0 = 1'b0, m_hist1 = 1'b0;  // pll_lock seen one and two edges ago
   bit   m_rst = 1'b1, m_rdy = 1'b0, m_err = 1'b0;
   int   m_retry = 0, m_loss = 0;
   bit   m_valid = 1'b0;

   always @(posedge clk_ref) begin
      bit seen;
      seen = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = pll_lock;
      if (!reset_n) begin
         m_valid = 1'b1;
         m_hist0 = 1'b0; m_hist1 = 1'b0;
         m_phase = P_HOLD; m_elapsed = 0;
         m_rst = 1'b1; m_rdy = 1'b0; m_err = 1'b0; m_retry = 0; m_loss = 0;
      end else if (pll_restart) begin
         m_phase = P_HOLD; m_elapsed = 0;
         m_rst = 1'b1; m_rdy = 1'b0; m_err = 1'b0; m_retry = 0;
      end else begin
         case (m_phase)
            P_HOLD: begin
               m_elapsed++;
               if (m_elapsed == RSTC) begin
                  m_phase = P_WAIT; m_elapsed = 0; m_rst = 1'b0;
               end
            end
            P_WAIT: begin
               if (seen) begin
                  m_phase = P_QUAL; m_elapsed = 0;
               end else begin
                  m_elapsed++;
                  if (m_elapsed == TMO) begin
                     m_elapsed = 0;
                     m_rst = 1'b1;
                     if (m_retry == MAXR) begin
                        m_phase = P_PARK; m_err = 1'b1;
                     end else begin
                        m_phase = P_HOLD;
                        m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                     end
                  end
               end
            end
            P_QUAL: begin
               if (!seen) begin
                  m_phase = P_WAIT; m_elapsed = 0;
               end else begin
                  m_elapsed++;
                  if (m_elapsed == STB) begin
                     m_phase = P_UP; m_rdy = 1'b1;
                  end
               end
            end
            P_UP: begin
               if (!seen) begin
                  m_phase = P_HOLD; m_elapsed = 0;
                  m_rdy = 1'b0; m_rst = 1'b1; m_retry = 0;
                  m_loss = (m_loss < 255) ? m_loss + 1 : 255;
               end
            end
            default: ;
         endcase
      end
   end

   // Per-cycle comparison against the model, plus the ready invariant
   always @(negedge clk_ref) begin
      if (m_valid) begin
         checks++;
         if ({pll_reset, pll_ready, lock_err, retry_cnt, loss_cnt} !==
             {m_rst, m_rdy, m_err, 3'(m_retry), 8'(m_loss)}) begin
            errors++;
            $display("FAIL model t=%0t got rst=%b rdy=%b err=%b retry=%0d loss=%0d, want rst=%b rdy=%b err=%b retry=%0d loss=%0d",
                     $time, pll_reset, pll_ready, lock_err, retry_cnt, loss_cnt,
                     m_rst, m_rdy, m_err, m_retry, m_loss);
         end
         if (pll_ready === 1'b1) begin
            checks++;
            if (pll_reset !== 1'b0 || lock_err !== 1'b0) begin
               errors++;
               $display("FAIL ready_invariant t=%0t got rst=%b err=%b, want 0 0",
                        $time, pll_reset, lock_err);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_ref);
   endtask

   function automatic int sig(input int which);
      case (which)
         0:       return int'(pll_reset);
         1:       return int'(pll_ready);
         2:       return int'(lock_err);
         3:       return int'(retry_cnt);
         default: return int'(loss_cnt);
      endcase
   endfunction

   // Step until a status output reaches a value; an expired budget fails the check
   task automatic wait_for(input string nm, input int which, input int val, input int budget);
      int n;
      n = 0;
      while (sig(which) != val && n < budget) begin
         step(1);
         n++;
      end
      chk(nm, sig(which), val);
   endtask

   // Count cycles pll_reset stays high from now; returns with pll_reset low
   task automatic pulse_len(output int n);
      n = 0;
      while (pll_reset === 1'b1 && n < 100) begin
         n++;
         step(1);
      end
   endtask

   // Cycles until pll_ready rises, bounded
   task automatic ready_lat(output int k);
      k = 0;
      while (pll_ready !== 1'b1 && k < 200) begin
         step(1);
         k++;
      end
   endtask

   task automatic restart_pulse();
      pll_restart = 1'b1;
      step(1);
      pll_restart = 1'b0;
   endtask

   initial begin
      int n;
      int k;

      // Reset values
      step(2);
      chk("rst_pll_reset", pll_reset, 1);
      chk("rst_pll_ready", pll_ready, 0);
      chk("rst_lock_err", lock_err, 0);
      chk("rst_retry", retry_cnt, 0);
      chk("rst_loss", loss_cnt, 0);

      // 1: nominal lock
      reset_n = 1'b1;
      pulse_len(n);
      chk("t1_pulse_len", n, 4);
      step(9);
      pll_lock = 1'b1;
      ready_lat(k);
      chk("t1_ready_latency", k, 11);
      chk("t1_retry", retry_cnt, 0);

      // 2: lock glitch during qualification
      pll_lock = 1'b0;
      restart_pulse();
      chk("t2_restart_ready", pll_ready, 0);
      pulse_len(n);
      chk("t2_pulse_len", n, 4);
      pll_lock = 1'b1;
      step(6);
      pll_lock = 1'b0;
      step(3);
      pll_lock = 1'b1;
      ready_lat(k);
      chk("t2_requal_latency", k, 11);
      chk("t2_retry", retry_cnt, 0);

      // 3: timeouts, retries, FAIL and restart out of it
      pll_lock = 1'b0;
      restart_pulse();
      wait_for("t3_retry1", 3, 1, 100);
      pulse_len(n);
      chk("t3_pulse1_len", n, 4);
      wait_for("t3_retry2", 3, 2, 100);
      pulse_len(n);
      chk("t3_pulse2_len", n, 4);
      wait_for("t3_lock_err", 2, 1, 100);
      chk("t3_fail_reset", pll_reset, 1);
      chk("t3_fail_retry", retry_cnt, 2);
      step(5);
      chk("t3_err_sticky", lock_err, 1);
      chk("t3_parked", pll_reset, 1);
      restart_pulse();
      chk("t3_err_cleared", lock_err, 0);
      chk("t3_retry_cleared", retry_cnt, 0);
      pulse_len(n);
      chk("t3_new_pulse_len", n, 4);
      pll_lock = 1'b1;
      wait_for("t3_relock", 1, 1, 60);

      // 4: loss of lock in READY (2 sync cycles, then the registered edge)
      pll_lock = 1'b0;
      step(2);
      chk("t4_ready_held", pll_ready, 1);
      step(1);
      chk("t4_ready_drop", pll_ready, 0);
      chk("t4_reset_rise", pll_reset, 1);
      chk("t4_loss1", loss_cnt, 1);
      pll_lock = 1'b1;
      wait_for("t4_relock", 1, 1, 60);
      for (int i = 0; i < 299; i++) begin
         pll_lock = 1'b0;
         step(3);
         pll_lock = 1'b1;
         wait_for("t4_loop_relock", 1, 1, 60);
      end
      chk("t4_loss_saturated", loss_cnt, 255);

      // 5: lock_s rises on the final WAIT_LOCK cycle
      pll_lock = 1'b0;
      restart_pulse();
      wait_for("t5_reset_fall", 0, 0, 20);
      step(29);
      pll_lock = 1'b1;
      step(4);
      chk("t5_no_retry", retry_cnt, 0);
      chk("t5_no_pulse", pll_reset, 0);
      ready_lat(k);
      chk("t5_ready_after_tie", k, 7);

      // 6: reset_n during qualification, then during FAIL
      restart_pulse();
      wait_for("t6_reset_fall", 0, 0, 20);
      step(3);
      reset_n = 1'b0;
      step(1);
      chk("t6a_reset", pll_reset, 1);
      chk("t6a_ready", pll_ready, 0);
      chk("t6a_err", lock_err, 0);
      chk("t6a_retry", retry_cnt, 0);
      chk("t6a_loss", loss_cnt, 0);
      reset_n = 1'b1;
      pll_lock = 1'b0;
      wait_for("t6_fail", 2, 1, 300);
      reset_n = 1'b0;
      step(1);
      chk("t6b_reset", pll_reset, 1);
      chk("t6b_ready", pll_ready, 0);
      chk("t6b_err", lock_err, 0);
      chk("t6b_retry", retry_cnt, 0);
      chk("t6b_loss", loss_cnt, 0);
      reset_n = 1'b1;
      step(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
